// File: rtl/osc_noise_multi_pkg.sv
// Shared constants and helpers for the multi-channel LFSR noise oscillator.
// Seeds and tap masks describe Galois right-shift LFSRs: a 16-bit long mode
// (x^16+x^15+x^13+x^4+1) and a 7-bit short mode (x^7+x^6+1).
package osc_noise_pkg;

    localparam logic [15:0] LONG_SEED  = 16'hACE1;
    localparam logic [15:0] SHORT_SEED = 16'h0061;
    localparam logic [15:0] LONG_TAPS  = 16'hD008;
    localparam logic [15:0] SHORT_TAPS = 16'h0060;
    localparam logic [15:0] SHORT_MASK = 16'h007F;

    // One LFSR step in the selected mode. A mode-masked all-zero state would
    // never leave zero, so it is replaced by that mode's seed instead.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state,
                                              input logic        short_mode);
        logic [15:0] masked;
        logic [15:0] taps;
        masked = short_mode ? (state & SHORT_MASK) : state;
        taps   = short_mode ? SHORT_TAPS : LONG_TAPS;
        if (masked == 16'h0000) begin
            return short_mode ? SHORT_SEED : LONG_SEED;
        end
        return (masked >> 1) ^ (state[0] ? taps : 16'h0000);
    endfunction

    // Two's-complement negate of a width-bit signed value held sign-extended
    // in 32 bits; the most negative value maps to the most positive one.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] value,
                                                   input int unsigned        width);
        logic signed [31:0] min_v;
        min_v = $signed(32'hFFFF_FFFF << (width - 1));
        if (value == min_v) begin
            return ~min_v;
        end
        return -value;
    endfunction

endpackage

// File: rtl/osc_noise_multi_if.sv
// Control/sample bundle between a controller (master) and the noise block (slave).
interface osc_noise_multi_if #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 17,
    parameter int PERIOD_W = 17
);
    logic                               sample_tick;
    logic [NUM_CH-1:0]                  en;
    logic [NUM_CH-1:0]                  short_mode;
    logic [NUM_CH-1:0]                  trig;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]    volume;
    logic [NUM_CH-1:0][PERIOD_W-1:0]    period;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]    ch_sample;
    logic [SAMPLE_W-1:0]                mix;
    logic                               mix_valid;

    modport master (
        output sample_tick, en, short_mode, trig, volume, period,
        input  ch_sample, mix, mix_valid
    );

    modport slave (
        input  sample_tick, en, short_mode, trig, volume, period,
        output ch_sample, mix, mix_valid
    );
endinterface

// File: rtl/osc_noise_multi_lfsr_ch.sv
// One noise channel: period counter, 16-bit LFSR and registered signed sample.
module noise_lfsr_ch
    import osc_noise_pkg::*;
#(
    parameter int SAMPLE_W = 17,
    parameter int PERIOD_W = 17
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic                       en,
    input  logic                       short_mode,
    input  logic                       trig,
    input  logic signed [SAMPLE_W-1:0] volume,
    input  logic [PERIOD_W-1:0]        period,
    output logic [SAMPLE_W-1:0]        ch_sample
);

    logic [15:0]         lfsr_reg;
    logic [PERIOD_W-1:0] counter_reg;
    logic [SAMPLE_W-1:0] ch_sample_reg;

    // LFSR/counter update: reset beats reseed, reseed beats a tick step.
    // Using >= lets a period lowered mid-count take effect immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg    <= LONG_SEED;
            counter_reg <= '0;
        end else if (trig) begin
            lfsr_reg    <= short_mode ? SHORT_SEED : LONG_SEED;
            counter_reg <= '0;
        end else if (sample_tick) begin
            if (counter_reg >= period) begin
                lfsr_reg    <= lfsr_step(lfsr_reg, short_mode);
                counter_reg <= '0;
            end else begin
                counter_reg <= counter_reg + PERIOD_W'(1);
            end
        end
    end

    // Output sample: LFSR bit 0 selects +volume or saturated -volume.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_sample_reg <= '0;
        end else if (!en) begin
            ch_sample_reg <= '0;
        end else if (lfsr_reg[0]) begin
            ch_sample_reg <= volume;
        end else begin
            ch_sample_reg <= SAMPLE_W'(sat_neg(32'(volume), SAMPLE_W));
        end
    end

    assign ch_sample = ch_sample_reg;

endmodule

// File: rtl/osc_noise_multi.sv
// Multi-channel LFSR noise oscillator: NUM_CH independent channels, a
// saturating mixer and a tick delay line that flags each new mix.
module osc_noise_multi
    import osc_noise_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 17,
    parameter int PERIOD_W = 17
) (
    input  logic           clk,
    input  logic           rst,
    osc_noise_multi_if.slave bus
);

    // Enough headroom to sum every channel without wrapping.
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH);
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] ch_sample_w;
    logic signed [SUM_W-1:0]         sum_next;
    logic signed [SAMPLE_W-1:0]      mix_next;
    logic signed [SAMPLE_W-1:0]      mix_reg;
    logic [2:0]                      tick_pipe_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            noise_lfsr_ch #(
                .SAMPLE_W (SAMPLE_W),
                .PERIOD_W (PERIOD_W)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .sample_tick (bus.sample_tick),
                .en          (bus.en[gi]),
                .short_mode  (bus.short_mode[gi]),
                .trig        (bus.trig[gi]),
                .volume      (bus.volume[gi]),
                .period      (bus.period[gi]),
                .ch_sample   (ch_sample_w[gi])
            );
        end
    endgenerate

    // Wide signed sum of the registered channel samples, clamped to SAMPLE_W.
    always_comb begin
        sum_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_next = sum_next + SUM_W'($signed(ch_sample_w[i]));
        end
        if (sum_next > SUM_MAX) begin
            mix_next = SAMPLE_W'(SUM_MAX);
        end else if (sum_next < SUM_MIN) begin
            mix_next = SAMPLE_W'(SUM_MIN);
        end else begin
            mix_next = SAMPLE_W'(sum_next);
        end
    end

    // Mix register, one stage after the channel samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_reg <= '0;
        end else begin
            mix_reg <= mix_next;
        end
    end

    // Tick delay line matching LFSR -> sample -> mix; reset drops ticks in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_pipe_reg <= '0;
        end else begin
            tick_pipe_reg <= {tick_pipe_reg[1:0], bus.sample_tick};
        end
    end

    assign bus.ch_sample = ch_sample_w;
    assign bus.mix       = mix_reg;
    assign bus.mix_valid = tick_pipe_reg[2];

endmodule

// File: tb/tb_osc_noise_multi.sv
// Self-checking bench for osc_noise_multi: table vectors, directed corner
// sequences and a randomized run against a behavioural model.
module tb_osc_noise_multi;

    localparam int NCH  = 4;
    localparam int SW   = 17;
    localparam int PW   = 17;
    localparam int MAXV = (1 << (SW - 1)) - 1;
    localparam int MINV = -(1 << (SW - 1));

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    osc_noise_multi_if #(.NUM_CH(NCH), .SAMPLE_W(SW), .PERIOD_W(PW)) bus ();

    osc_noise_multi #(.NUM_CH(NCH), .SAMPLE_W(SW), .PERIOD_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state (values after the most recent clock edge).
    int m_lfsr [NCH];
    int m_cnt  [NCH];
    int m_ch   [NCH];
    int m_mix;
    int m_hist [$] = '{0, 0, 0};   // ticks sampled at the last three edges, newest first
    int m_valid;

    typedef struct packed {
        logic [3:0][16:0] vol;
        logic [3:0]       en;
        logic             stepped;
        logic [3:0][16:0] exp_ch;
        logic [16:0]      exp_mix;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [16:0] s17(input int v);
        return 17'(v);
    endfunction

    function automatic int clamp(input int s);
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
    endfunction

    function automatic int neg_sat(input int v);
        return (v == MINV) ? MAXV : -v;
    endfunction

    // Step rule written straight from the mode formulas.
    function automatic int m_step(input int s, input bit sh);
        int m;
        m = sh ? (s & 'h7F) : s;
        if (m == 0) return sh ? 'h0061 : 'hACE1;
        if (sh) return (m >> 1) ^ (((s & 1) != 0) ? 'h0060 : 0);
        return (m >> 1) ^ (((s & 1) != 0) ? 'hD008 : 0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock: predict from current inputs, clock, compare outputs.
    task automatic step_cycle();
        int n_lfsr [NCH];
        int n_cnt  [NCH];
        int n_ch   [NCH];
        int n_mix, sum, v, p;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                n_lfsr[i] = 'hACE1;
                n_cnt[i]  = 0;
                n_ch[i]   = 0;
            end
            n_mix  = 0;
            m_hist = '{0, 0, 0};
        end else begin
            sum = 0;
            for (int i = 0; i < NCH; i++) sum += m_ch[i];
            n_mix = clamp(sum);
            for (int i = 0; i < NCH; i++) begin
                v = $signed(bus.volume[i]);
                if (!bus.en[i]) n_ch[i] = 0;
                else n_ch[i] = ((m_lfsr[i] & 1) != 0) ? v : neg_sat(v);
                n_lfsr[i] = m_lfsr[i];
                n_cnt[i]  = m_cnt[i];
                p = int'(bus.period[i]);
                if (bus.trig[i]) begin
                    n_lfsr[i] = bus.short_mode[i] ? 'h0061 : 'hACE1;
                    n_cnt[i]  = 0;
                end else if (bus.sample_tick) begin
                    if (m_cnt[i] >= p) begin
                        n_lfsr[i] = m_step(m_lfsr[i], bus.short_mode[i]);
                        n_cnt[i]  = 0;
                    end else begin
                        n_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            m_hist.push_front(int'(bus.sample_tick));
            void'(m_hist.pop_back());
        end
        @(posedge clk);
        #1;
        m_lfsr  = n_lfsr;
        m_cnt   = n_cnt;
        m_ch    = n_ch;
        m_mix   = n_mix;
        m_valid = m_hist[2];
        for (int i = 0; i < NCH; i++)
            chk($sformatf("ch_sample[%0d]", i), $signed(bus.ch_sample[i]), m_ch[i]);
        chk("mix", $signed(bus.mix), m_mix);
        chk("mix_valid", int'(bus.mix_valid), m_valid);
    endtask

    task automatic idle_inputs();
        bus.sample_tick = 1'b0;
        bus.trig        = '0;
        bus.short_mode  = '0;
        bus.en          = '0;
        bus.period      = '0;
        bus.volume      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int found;
        int r;

        vecs[0] = '{vol: {s17(32767), s17(32767), s17(32767), s17(32767)}, en: 4'hF, stepped: 1'b0,
                    exp_ch: {s17(32767), s17(32767), s17(32767), s17(32767)}, exp_mix: s17(65535)};
        vecs[1] = '{vol: {s17(-65536), s17(-65536), s17(-65536), s17(-65536)}, en: 4'hF, stepped: 1'b1,
                    exp_ch: {s17(65535), s17(65535), s17(65535), s17(65535)}, exp_mix: s17(65535)};
        vecs[2] = '{vol: {s17(-65536), s17(-65536), s17(-65536), s17(-65536)}, en: 4'hF, stepped: 1'b0,
                    exp_ch: {s17(-65536), s17(-65536), s17(-65536), s17(-65536)}, exp_mix: s17(-65536)};
        vecs[3] = '{vol: {s17(4000), s17(3000), s17(2000), s17(1000)}, en: 4'hF, stepped: 1'b1,
                    exp_ch: {s17(-4000), s17(-3000), s17(-2000), s17(-1000)}, exp_mix: s17(-10000)};
        vecs[4] = '{vol: {s17(-4000), s17(3000), s17(-2000), s17(1000)}, en: 4'b0101, stepped: 1'b0,
                    exp_ch: {s17(0), s17(3000), s17(0), s17(1000)}, exp_mix: s17(4000)};
        vecs[5] = '{vol: {s17(100), s17(100), s17(100), s17(100)}, en: 4'h0, stepped: 1'b0,
                    exp_ch: {s17(0), s17(0), s17(0), s17(0)}, exp_mix: s17(0)};
        vecs[6] = '{vol: {s17(5), s17(-20000), s17(30000), s17(30000)}, en: 4'hF, stepped: 1'b0,
                    exp_ch: {s17(5), s17(-20000), s17(30000), s17(30000)}, exp_mix: s17(40005)};

        // Reset state
        idle_inputs();
        do_reset();
        do_reset();
        $display("[TB] reset: mix=%0d mix_valid=%0d", $signed(bus.mix), bus.mix_valid);

        // Table vectors: static sign/saturation/mix cases
        for (int k = 0; k < 7; k++) begin
            idle_inputs();
            bus.volume = vecs[k].vol;
            bus.en     = vecs[k].en;
            do_reset();
            if (vecs[k].stepped) begin
                bus.sample_tick = 1'b1;
                step_cycle();
                bus.sample_tick = 1'b0;
            end
            repeat (3) step_cycle();
            for (int i = 0; i < NCH; i++)
                chk($sformatf("vec%0d_ch[%0d]", k, i), $signed(bus.ch_sample[i]), $signed(vecs[k].exp_ch[i]));
            chk($sformatf("vec%0d_mix", k), $signed(bus.mix), $signed(vecs[k].exp_mix));
            $display("[TB] vector %0d: mix=%0d", k, $signed(bus.mix));
        end

        // First long step and latency: tick in t -> sample t+2 -> mix/valid t+3
        idle_inputs();
        bus.en[0] = 1'b1;
        bus.volume[0] = s17(1000);
        do_reset();
        step_cycle();
        bus.sample_tick = 1'b1;
        step_cycle();
        bus.sample_tick = 1'b0;
        chk("lat_ch_t1", $signed(bus.ch_sample[0]), 1000);
        chk("lat_valid_t1", int'(bus.mix_valid), 0);
        step_cycle();
        chk("lat_ch_t2", $signed(bus.ch_sample[0]), -1000);
        chk("lat_valid_t2", int'(bus.mix_valid), 0);
        step_cycle();
        chk("lat_mix_t3", $signed(bus.mix), -1000);
        chk("lat_valid_t3", int'(bus.mix_valid), 1);
        step_cycle();
        chk("lat_valid_t4", int'(bus.mix_valid), 0);
        $display("[TB] long step latency: ch0=%0d", $signed(bus.ch_sample[0]));

        // Period 3: three ticks do not step, idle cycles do not step, fourth steps
        idle_inputs();
        bus.en[0] = 1'b1;
        bus.volume[0] = s17(1);
        bus.period[0] = PW'(3);
        do_reset();
        bus.sample_tick = 1'b1;
        repeat (3) step_cycle();
        bus.sample_tick = 1'b0;
        repeat (5) step_cycle();
        chk("period_hold", $signed(bus.ch_sample[0]), 1);
        bus.sample_tick = 1'b1;
        step_cycle();
        bus.sample_tick = 1'b0;
        repeat (2) step_cycle();
        chk("period_step", $signed(bus.ch_sample[0]), -1);
        bus.sample_tick = 1'b1;
        repeat (16) step_cycle();
        $display("[TB] period 3 sequence done");

        // Short mode: reseed, first step 0x61 -> 0x50, then a full cycle
        idle_inputs();
        bus.en[0] = 1'b1;
        bus.volume[0] = s17(9);
        bus.short_mode[0] = 1'b1;
        do_reset();
        bus.trig[0] = 1'b1;
        bus.sample_tick = 1'b1;
        step_cycle();
        bus.trig[0] = 1'b0;
        step_cycle();
        bus.sample_tick = 1'b0;
        chk("short_seed_ch", $signed(bus.ch_sample[0]), 9);
        step_cycle();
        chk("short_step1_ch", $signed(bus.ch_sample[0]), -9);
        chk("short_model_state", m_lfsr[0], 'h0050);
        bus.sample_tick = 1'b1;
        repeat (130) step_cycle();
        $display("[TB] short mode cycle done");

        // Lockup: long state with zero low 7 bits, switch to short, tick -> seed
        idle_inputs();
        bus.en[0] = 1'b1;
        bus.volume[0] = s17(7);
        do_reset();
        bus.sample_tick = 1'b1;
        found = 0;
        for (int n = 0; n < 4000 && found == 0; n++) begin
            step_cycle();
            if ((m_lfsr[0] & 'h7F) == 0) found = 1;
        end
        chk("lockup_search", found, 1);
        bus.short_mode[0] = 1'b1;
        step_cycle();
        bus.sample_tick = 1'b0;
        step_cycle();
        chk("lockup_seed_ch", $signed(bus.ch_sample[0]), 7);
        step_cycle();
        chk("lockup_valid", int'(bus.mix_valid), 1);
        $display("[TB] lockup recovery: ch0=%0d", $signed(bus.ch_sample[0]));

        // Reset mid-sequence with trig and tick high
        idle_inputs();
        bus.en = 4'hF;
        bus.volume = {s17(11), s17(22), s17(33), s17(44)};
        bus.sample_tick = 1'b1;
        repeat (2) step_cycle();
        bus.trig = 4'hF;
        bus.short_mode = 4'hF;
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        chk("rst_mix", $signed(bus.mix), 0);
        chk("rst_valid", int'(bus.mix_valid), 0);
        for (int i = 0; i < NCH; i++)
            chk($sformatf("rst_ch[%0d]", i), $signed(bus.ch_sample[i]), 0);
        idle_inputs();
        for (int n = 0; n < 4; n++) begin
            step_cycle();
            chk($sformatf("rst_no_valid_%0d", n), int'(bus.mix_valid), 0);
        end
        $display("[TB] mid-sequence reset done");

        // Randomized run against the model
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.sample_tick = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) bus.short_mode = 4'($urandom);
            bus.en = 4'($urandom);
            for (int i = 0; i < NCH; i++) begin
                bus.trig[i] = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 15) == 0) bus.period[i] = PW'($urandom_range(0, 3));
                r = $urandom_range(0, 3);
                case (r)
                    0:       bus.volume[i] = s17(MINV);
                    1:       bus.volume[i] = s17(MAXV);
                    default: bus.volume[i] = 17'($urandom);
                endcase
            end
            step_cycle();
        end
        rst = 1'b0;
        $display("[TB] random run done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
